// File: rtl/prog_counter.sv
// prog_counter: WIDTH-bit programmable counter with limit, direction, four modes,
// tick prescaler and registered terminal-count pulse.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done,
  output logic                  dir_q
);
  localparam logic [WIDTH-1:0]      ONE  = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PONE = PRESCALE_W'(1);
  logic [WIDTH-1:0]      cnt_q, cnt_d, nxt;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tc_q, tc_d, done_q, done_d, dq_q, dq_d;
  logic                  tick, up, ev, act;
  always_comb begin
    tick = ena && (pre_q >= prescale);
    up   = (mode == 2'd2) ? !dq_q : !dir;
    nxt  = cnt_q;
    ev   = 1'b0;
    if (mode == 2'd0) begin
      if (up) begin
        nxt = (cnt_q >= limit) ? '0 : cnt_q + ONE;
        ev  = cnt_q >= limit;
      end else begin
        nxt = (cnt_q == '0 || cnt_q > limit) ? limit : cnt_q - ONE;
        ev  = cnt_q == '0;
      end
    end else if (mode == 2'd2) begin
      // limit==0 pins the count at 0 while every tick still bounces
      if (up) begin
        nxt = (cnt_q >= limit) ? ((limit == '0) ? '0 : limit - ONE) : cnt_q + ONE;
        ev  = cnt_q >= limit;
      end else begin
        nxt = (cnt_q == '0) ? ((limit == '0) ? '0 : ONE) : cnt_q - ONE;
        ev  = cnt_q == '0;
      end
    end else begin
      if (up) begin
        nxt = (cnt_q < limit) ? cnt_q + ONE : limit;
        ev  = (cnt_q < limit) && (nxt == limit);
      end else begin
        nxt = (cnt_q != '0) ? cnt_q - ONE : '0;
        ev  = cnt_q == ONE;
      end
    end
    act    = tick && !(mode == 2'd3 && done_q);
    cnt_d  = load ? ((load_val > limit) ? limit : load_val) : act ? nxt : cnt_q;
    pre_d  = (load || tick) ? '0 : ena ? pre_q + PONE : pre_q;
    tc_d   = !load && act && ev;
    done_d = load ? 1'b0 : (act && ev && mode == 2'd3) ? 1'b1 : done_q;
    dq_d   = (load || mode != 2'd2) ? dir : (act && ev) ? !dq_q : dq_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
      dq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      tc_q   <= tc_d;
      done_q <= done_d;
      dq_q   <= dq_d;
    end
  end
  assign count = cnt_q;
  assign tc    = tc_q;
  assign done  = done_q;
  assign dir_q = dq_q;
endmodule
